cp_host: RTL and testbench
==========================

# cp_host

Host-side initiator for the co-processor serial-result link. Accepts a request (2-bit opcode plus 8-bit operand) over a valid/ready handshake and drives the co-processor's `r0`/`check` inputs for one cycle. It then deserializes the framed 1-bit result returned on the co-processor's `Q` line and presents the byte, with error flags, on a response handshake. Sits between on-chip request logic and the co-processor, in the same clock domain.

## Interface
Parameters:
- `TIMEOUT`, 64: max cycles spent waiting for a start bit before aborting; must be ≥2.

Ports:
- `clk`  in  1  system clock, all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_op`  in  2  opcode; `2'b00` is NOP.
- `req_operand`  in  8  operand byte.
- `cp_r0`  out  8  operand to co-processor `r0`.
- `cp_check`  out  2  opcode strobe to co-processor `check`; `2'b00` = idle.
- `cp_q`  in  1  serial result from co-processor `Q`, synchronous to `clk`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  8  result byte.
- `rsp_err`  out  2  bit0 framing error (bad stop bit), bit1 timeout.

## Operation
- Frame on `cp_q`: idle 1; start bit 0; 8 data bits LSB first; stop bit 1. One bit per clock.
- States: IDLE, ISSUE, WAIT_START, DATA, STOP, DONE.
- IDLE: `req_ready`=1. On `req_valid`: latch op/operand. If op≠00, go to ISSUE. If op=00, go to DONE with data 00 and err 00; the bus is not driven.
- ISSUE (1 cycle): `cp_check`=latched op, `cp_r0`=latched operand. Go to WAIT_START; clear timeout counter.
- WAIT_START: `cp_check`=00. `cp_r0` holds the operand until DONE.
  - `cp_q`=0: go to DATA, bit index 0.
  - Otherwise increment the counter. At count `TIMEOUT`-1 with `cp_q` still 1: go to DONE with data 00 and err `2'b10`.
- DATA: shift `cp_q` into bit[index]. After index 7, go to STOP.
- STOP: sample `cp_q`. Set err bit0 if the sample is 0. Go to DONE.
- DONE: `rsp_valid`=1. `rsp_data`/`rsp_err` are stable until `rsp_valid && rsp_ready`, then go to IDLE; `cp_r0` returns to 00.
- `cp_q` is ignored outside WAIT_START/DATA/STOP. A low level in IDLE or ISSUE never starts a frame.
- A framing error still delivers the assembled data byte.
- Reset (any state, asynchronous): state IDLE; `cp_r0`=00; `cp_check`=00; `rsp_valid`=0; `rsp_data`=00; `rsp_err`=00; counters 0; `req_ready`=1 after reset deasserts.

## Timing
- Request accepted at edge 0. `cp_check` is non-zero during cycle 1 only.
- Earliest start bit is sampled in cycle 2, data bits in cycles 3–10, stop bit in cycle 11. `rsp_valid` rises in cycle 12.
- NOP: `rsp_valid` is high in cycle 1.
- Timeout: `rsp_valid` is high exactly `TIMEOUT`+2 cycles after acceptance.
- With `rsp_ready` held high, `rsp_valid` lasts one cycle and `req_ready` returns the next cycle. There is no request/response overlap: one transaction outstanding.
- All outputs are registered.

## Structure
- Shared package `cp_link_pkg`:
  - opcode constants `CP_OP_NOP`=2'b00, plus the three active codes;
  - state enum;
  - `CP_FRAME_BITS`=8;
  - error bit positions.
- One natural sub-module, `cp_frame_rx`: start detect, timeout counter, 8-bit shift register and stop check. It has a start/enable input and a done/data/err output. `cp_host` holds the handshake FSM and bus drive.

## Test plan
- Op 01, operand 8'h5A; responder returns start, 8'hC3 LSB-first, stop 1 → `cp_check`=01 for exactly cycle 1; `rsp_data`=C3 and `rsp_err`=00 with `rsp_valid` at cycle 12.
- Op 00 → no `cp_check` activity; `rsp_valid` in cycle 1 with data 00, err 00.
- Op 10; `cp_q` held 1 for 64 cycles → `rsp_err`=10, `rsp_data`=00 at cycle 66.
- Op 11; frame 8'hFF with stop bit 0 → `rsp_data`=FF, `rsp_err`=01.
- `rsp_ready` low 5 cycles at DONE → data/err stable, `req_ready`=0 throughout. A pulse of `cp_q`=0 in IDLE before the next request starts no frame.
- `rst_n` asserted mid-DATA (bit 4) → all outputs reset immediately. The next request with frame 8'h81 completes correctly.

Source files
------------

// File: rtl/cp_link_pkg.sv
// Shared definitions for the co-processor serial-result link.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cp_link_pkg;

    localparam logic [1:0] CP_OP_NOP = 2'b00;
    localparam logic [1:0] CP_OP_A   = 2'b01;
    localparam logic [1:0] CP_OP_B   = 2'b10;
    localparam logic [1:0] CP_OP_C   = 2'b11;

    localparam int CP_FRAME_BITS = 8;

    localparam int CP_ERR_FRAME   = 0;
    localparam int CP_ERR_TIMEOUT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } cp_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_HUNT,
        RX_DATA,
        RX_STOP
    } rx_phase_t;

    typedef struct packed {
        logic [1:0]               err;
        logic [CP_FRAME_BITS-1:0] dat;
    } rsp_t;

endpackage

// File: rtl/cp_frame_rx.sv
// Deserializes one start/8-data/stop frame from cp_q, with start-bit timeout.
// Latency: done asserts combinationally in the stop-bit (or timeout) cycle.
// Backpressure: none; the host consumes done the cycle it is raised.
module cp_frame_rx
    import cp_link_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic cp_q,
    output logic sof_vld,
    output logic last_vld,
    output logic done_vld,
    output rsp_t done_dat
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [2:0]    IDX_LAST = 3'(CP_FRAME_BITS - 1);

    rx_phase_t                phase_q, phase_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [2:0]               idx_q, idx_d;
    logic [CP_FRAME_BITS-1:0] shift_q, shift_d;

    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        sof_vld  = 1'b0;
        last_vld = 1'b0;
        done_vld = 1'b0;
        done_dat = '0;
        case (phase_q)
            RX_IDLE: begin
                if (start) begin
                    phase_d = RX_HUNT;
                    cnt_d   = '0;
                end
            end
            RX_HUNT: begin
                // A start bit in the final hunt cycle still wins over the timeout.
                if (!cp_q) begin
                    sof_vld = 1'b1;
                    phase_d = RX_DATA;
                    idx_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    done_vld                    = 1'b1;
                    done_dat.err[CP_ERR_TIMEOUT] = 1'b1;
                    phase_d                     = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                shift_d[idx_q] = cp_q;
                idx_d          = idx_q + 3'd1;
                if (idx_q == IDX_LAST) begin
                    last_vld = 1'b1;
                    phase_d  = RX_STOP;
                end
            end
            RX_STOP: begin
                done_vld                   = 1'b1;
                done_dat.dat               = shift_q;
                done_dat.err[CP_ERR_FRAME] = ~cp_q;
                phase_d                    = RX_IDLE;
            end
            default: phase_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/cp_host.sv
// Host initiator: issues an opcode/operand to the co-processor and returns its serial result.
// Latency: response 12 cycles after accept for an immediate start bit, 1 for NOP, TIMEOUT+2 on timeout.
// Backpressure: single outstanding transaction; req_ready stays low until the response handshakes.
module cp_host
    import cp_link_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_operand,
    output logic [7:0] cp_r0,
    output logic [1:0] cp_check,
    input  logic       cp_q,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [1:0] rsp_err
);

    cp_state_t  state_q, state_d;
    logic [1:0] cp_check_q, cp_check_d;
    logic [7:0] cp_r0_q, cp_r0_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       req_ready_q, req_ready_d;
    rsp_t       rsp_q, rsp_d;

    logic rx_sof, rx_last, rx_done;
    rsp_t rx_rsp;

    cp_frame_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (state_q == ST_ISSUE),
        .cp_q     (cp_q),
        .sof_vld  (rx_sof),
        .last_vld (rx_last),
        .done_vld (rx_done),
        .done_dat (rx_rsp)
    );

    always_comb begin
        state_d    = state_q;
        cp_check_d = '0;
        cp_r0_d    = cp_r0_q;
        rsp_d      = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    // NOP never touches the co-processor bus.
                    if (req_op != CP_OP_NOP) begin
                        state_d    = ST_ISSUE;
                        cp_check_d = req_op;
                        cp_r0_d    = req_operand;
                    end else begin
                        state_d = ST_DONE;
                        rsp_d   = '0;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT_START;
            ST_WAIT_START: begin
                if (rx_sof) begin
                    state_d = ST_DATA;
                end else if (rx_done) begin
                    state_d = ST_DONE;
                    rsp_d   = rx_rsp;
                end
            end
            ST_DATA: begin
                if (rx_last) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_done) begin
                    state_d = ST_DONE;
                    rsp_d   = rx_rsp;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    cp_r0_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rsp_valid_d = (state_d == ST_DONE);
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cp_check_q  <= '0;
            cp_r0_q     <= '0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cp_check_q  <= cp_check_d;
            cp_r0_q     <= cp_r0_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
            rsp_q       <= rsp_d;
        end
    end

    assign req_ready = req_ready_q;
    assign cp_check  = cp_check_q;
    assign cp_r0     = cp_r0_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q.dat;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_cp_host.sv
// Bench for cp_host: directed scenarios plus randomized transactions against a frame-level model.
module tb_cp_host;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_operand = 8'h00;
    logic [7:0] cp_r0;
    logic [1:0] cp_check;
    logic       cp_q = 1'b1;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;

    int n_vec = 0;
    int n_err = 0;

    cp_host #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_operand (req_operand),
        .cp_r0       (cp_r0),
        .cp_check    (cp_check),
        .cp_q        (cp_q),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    // Line level during cycle cyc after acceptance: idle high for dly cycles from cycle 2,
    // then start, 8 data bits LSB first, stop, idle.
    function automatic logic cpq_at(input int cyc, input int dly, input logic [7:0] byt, input logic stopb);
        logic [7:0] b;
        b = byt;
        if (cyc < 2 + dly)       return 1'b1;
        if (cyc == 2 + dly)      return 1'b0;
        if (cyc <= 10 + dly)     return b[3'(cyc - 3 - dly)];
        if (cyc == 11 + dly)     return stopb;
        return 1'b1;
    endfunction

    // One full transaction, entered and left #1 after a rising edge with the DUT idle.
    task automatic do_txn(input logic [1:0] op, input logic [7:0] operand, input int dly,
                          input logic [7:0] byt, input logic stopb, input int lag, input string name);
        int         exp_cyc;
        logic [7:0] exp_dat;
        logic [1:0] exp_err;
        logic [7:0] exp_r0;
        logic [1:0] exp_chk;
        int         last;
        if (op == 2'b00) begin
            exp_cyc = 1;      exp_dat = 8'h00; exp_err = 2'b00;
        end else if (dly >= TO) begin
            exp_cyc = TO + 2; exp_dat = 8'h00; exp_err = 2'b10;
        end else begin
            exp_cyc = 12 + dly; exp_dat = byt; exp_err = {1'b0, ~stopb};
        end
        exp_r0 = (op == 2'b00) ? 8'h00 : operand;
        last   = exp_cyc + lag + 1;

        req_valid = 1'b1; req_op = op; req_operand = operand;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'b00; req_operand = 8'h00;

        for (int cyc = 1; cyc <= last; cyc++) begin
            cp_q      = (op == 2'b00) ? 1'b1 : cpq_at(cyc, dly, byt, stopb);
            rsp_ready = (cyc >= exp_cyc + lag);
            if (cyc == last) begin
                n_vec++;
                if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || cp_r0 !== 8'h00) begin
                    n_err++;
                    $display("FAIL %s release cyc%0d: valid/ready/r0 got %b/%b/%h want 0/1/00",
                             name, cyc, rsp_valid, req_ready, cp_r0);
                end
            end else begin
                exp_chk = (cyc == 1) ? op : 2'b00;
                n_vec++;
                if (cp_check !== exp_chk) begin
                    n_err++;
                    $display("FAIL %s cp_check cyc%0d: got %b want %b", name, cyc, cp_check, exp_chk);
                end
                n_vec++;
                if (cp_r0 !== exp_r0) begin
                    n_err++;
                    $display("FAIL %s cp_r0 cyc%0d: got %h want %h", name, cyc, cp_r0, exp_r0);
                end
                n_vec++;
                if (req_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s req_ready cyc%0d: got %b want 0", name, cyc, req_ready);
                end
                n_vec++;
                if (rsp_valid !== (cyc >= exp_cyc)) begin
                    n_err++;
                    $display("FAIL %s rsp_valid cyc%0d: got %b want %b", name, cyc, rsp_valid, cyc >= exp_cyc);
                end
                if (cyc >= exp_cyc) begin
                    n_vec++;
                    if (rsp_data !== exp_dat || rsp_err !== exp_err) begin
                        n_err++;
                        $display("FAIL %s rsp cyc%0d: data/err got %h/%b want %h/%b",
                                 name, cyc, rsp_data, rsp_err, exp_dat, exp_err);
                    end
                end
                @(posedge clk); #1;
            end
        end
        cp_q      = 1'b1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (cp_r0 !== 8'h00 || cp_check !== 2'b00 || rsp_valid !== 1'b0 ||
            rsp_data !== 8'h00 || rsp_err !== 2'b00) begin
            n_err++;
            $display("FAIL reset_values: r0/chk/valid/data/err got %h/%b/%b/%h/%b want 00/00/0/00/00",
                     cp_r0, cp_check, rsp_valid, rsp_data, rsp_err);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: ready/valid got %b/%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_basic;
        do_txn(2'b01, 8'h5A, 0, 8'hC3, 1'b1, 0, "basic");
    endtask

    task automatic test_nop;
        do_txn(2'b00, 8'h77, 0, 8'h00, 1'b1, 0, "nop");
    endtask

    task automatic test_timeout;
        do_txn(2'b10, 8'h33, TO, 8'hA5, 1'b1, 0, "timeout");
    endtask

    task automatic test_frame_err;
        do_txn(2'b11, 8'h0F, 3, 8'hFF, 1'b0, 1, "frame_err");
    endtask

    task automatic test_backpressure;
        do_txn(2'b01, 8'h12, 1, 8'h6E, 1'b1, 5, "backpressure");
        for (int i = 0; i < 3; i++) begin
            cp_q = 1'b0;
            @(posedge clk); #1;
            n_vec++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || cp_check !== 2'b00) begin
                n_err++;
                $display("FAIL idle_pulse %0d: valid/ready/chk got %b/%b/%b want 0/1/00",
                         i, rsp_valid, req_ready, cp_check);
            end
        end
        cp_q = 1'b1;
        @(posedge clk); #1;
        do_txn(2'b10, 8'h44, 0, 8'h3C, 1'b1, 0, "after_idle_pulse");
    endtask

    task automatic test_reset_mid_data;
        logic [7:0] byt;
        byt = 8'hB6;
        req_valid = 1'b1; req_op = 2'b01; req_operand = 8'hE7;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'b00; req_operand = 8'h00;
        for (int cyc = 1; cyc < 7; cyc++) begin
            cp_q = cpq_at(cyc, 0, byt, 1'b1);
            @(posedge clk); #1;
        end
        cp_q = cpq_at(7, 0, byt, 1'b1);
        n_vec++;
        if (cp_r0 !== 8'hE7) begin
            n_err++;
            $display("FAIL mid_data_r0: got %h want e7", cp_r0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (cp_r0 !== 8'h00 || cp_check !== 2'b00 || rsp_valid !== 1'b0 ||
            rsp_data !== 8'h00 || rsp_err !== 2'b00 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_data_reset: r0/chk/valid/data/err/ready got %h/%b/%b/%h/%b/%b want 00/00/0/00/00/1",
                     cp_r0, cp_check, rsp_valid, rsp_data, rsp_err, req_ready);
        end
        cp_q = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_txn(2'b01, 8'h99, 0, 8'h81, 1'b1, 0, "after_reset");
    endtask

    task automatic test_random;
        logic [1:0] op;
        logic [7:0] operand, byt;
        logic       stopb;
        int         dly, lag, pick;
        for (int n = 0; n < 30; n++) begin
            op      = 2'($urandom_range(0, 3));
            operand = 8'($urandom);
            byt     = 8'($urandom);
            stopb   = ($urandom_range(0, 3) != 0);
            lag     = $urandom_range(0, 3);
            pick    = $urandom_range(0, 7);
            if (pick == 0)      dly = TO + $urandom_range(0, 3);
            else if (pick == 1) dly = TO - 1;
            else                dly = $urandom_range(0, 6);
            do_txn(op, operand, dly, byt, stopb, lag, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nop();
        test_timeout();
        test_frame_err();
        test_backpressure();
        test_reset_mid_data();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
